// File: rtl/seq_binary_multiplier.sv
// rtl/seq_binary_multiplier.sv - shift-add sequential multiplier, signed/unsigned per operation
// One partial product per clock; operands are magnitudes, the sign is applied once at the end.
module seq_binary_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic             r_sign;
   logic [CW-1:0]    r_cnt;
   logic             r_done;
   logic [PW-1:0]    r_product;

   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;
   logic [WIDTH:0]   w_sum;
   logic [PW-1:0]    w_full;
   logic [PW-1:0]    w_signed_full;

   // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
   assign w_mag_a = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
   assign w_mag_b = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

   assign w_sum = {1'b0, r_acc} + {1'b0, (r_mplier[0] ? r_mcand : '0)};

   // Low half of the accumulator shares the multiplier register as its bits are consumed
   assign w_full        = {r_acc, r_mplier};
   assign w_signed_full = r_sign ? (~w_full + PW'(1)) : w_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_sign    <= 1'b0;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mcand  <= w_mag_a;
                  r_mplier <= w_mag_b;
                  r_sign   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_state  <= CALC;
               end
            end
            CALC: begin
               r_acc    <= w_sum[WIDTH:1];
               r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
               r_cnt    <= r_cnt + CW'(1);
               if (r_cnt == LAST_STEP) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               r_product <= w_signed_full;
               r_done    <= 1'b1;
               r_state   <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy    = (r_state != IDLE);
   assign done    = r_done;
   assign product = r_product;

endmodule

// File: tb/tb_seq_binary_multiplier.sv
// tb/tb_seq_binary_multiplier.sv - directed checks of the sequential multiplier at WIDTH 4 and 8
module tb_seq_binary_multiplier;

   logic        clk;
   logic        rst_n;

   logic        start4, sg4, busy4, done4;
   logic [3:0]  a4, b4;
   logic [7:0]  product4;

   logic        start8, sg8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] product8;

   int errors;
   int checks;
   int lat;
   int nbusy;

   seq_binary_multiplier #(.WIDTH(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start4),
      .is_signed (sg4),
      .a         (a4),
      .b         (b4),
      .busy      (busy4),
      .done      (done4),
      .product   (product4)
   );

   seq_binary_multiplier #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start8),
      .is_signed (sg8),
      .a         (a8),
      .b         (b8),
      .busy      (busy8),
      .done      (done8),
      .product   (product8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called #1 after an edge; holds start through exactly one edge.
   task automatic begin_op(input bit w8, input bit sg, input logic [7:0] av, input logic [7:0] bv);
      if (w8) begin
         start8 = 1'b1; sg8 = sg; a8 = av; b8 = bv;
      end else begin
         start4 = 1'b1; sg4 = sg; a4 = av[3:0]; b4 = bv[3:0];
      end
      @(posedge clk); #1;
      start4 = 1'b0;
      start8 = 1'b0;
      a4 = 4'hA; b4 = 4'h5; sg4 = 1'b1;
      a8 = 8'hA5; b8 = 8'h5A; sg8 = 1'b1;
   endtask

   task automatic wait_done(input bit w8, output int n, output int nb);
      logic dn, bs;
      n  = 0;
      nb = 0;
      dn = w8 ? done8 : done4;
      bs = w8 ? busy8 : busy4;
      while (!dn && n < 40) begin
         if (bs) nb++;
         @(posedge clk); #1;
         n++;
         dn = w8 ? done8 : done4;
         bs = w8 ? busy8 : busy4;
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      start4 = 1'b0; sg4 = 1'b0; a4 = '0; b4 = '0;
      start8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_busy", {63'd0, busy4}, 64'd0);
      check_eq("reset_done", {63'd0, done4}, 64'd0);
      check_eq("reset_product", {56'd0, product4}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // unsigned 15*15, latency and busy width
      begin_op(1'b0, 1'b0, 8'd15, 8'd15);
      wait_done(1'b0, lat, nbusy);
      check_eq("u15x15_latency", 64'(lat), 64'd5);
      check_eq("u15x15_busy_cycles", 64'(nbusy), 64'd5);
      check_eq("u15x15_product", {56'd0, product4}, 64'h00E1);
      @(posedge clk); #1;
      check_eq("done_one_cycle", {63'd0, done4}, 64'd0);
      check_eq("product_holds", {56'd0, product4}, 64'h00E1);

      // signed corner cases
      begin_op(1'b0, 1'b1, 8'h08, 8'h08);
      wait_done(1'b0, lat, nbusy);
      check_eq("s_m8xm8", {56'd0, product4}, 64'h0040);
      begin_op(1'b0, 1'b1, 8'h0D, 8'h05);
      wait_done(1'b0, lat, nbusy);
      check_eq("s_m3x5", {56'd0, product4}, 64'h00F1);
      begin_op(1'b0, 1'b1, 8'h00, 8'h0B);
      wait_done(1'b0, lat, nbusy);
      check_eq("s_0xm5", {56'd0, product4}, 64'h0000);
      begin_op(1'b0, 1'b1, 8'h07, 8'h08);
      wait_done(1'b0, lat, nbusy);
      check_eq("s_7xm8", {56'd0, product4}, 64'h00C8);

      // unsigned squares sweep
      for (int i = 0; i < 16; i++) begin
         begin_op(1'b0, 1'b0, 8'(i), 8'(i));
         wait_done(1'b0, lat, nbusy);
         check_eq($sformatf("sq_%0d", i), {56'd0, product4}, 64'(i * i));
      end

      // start while busy is ignored
      begin_op(1'b0, 1'b0, 8'd3, 8'd5);
      @(posedge clk); #1;
      begin_op(1'b0, 1'b0, 8'd7, 8'd7);
      wait_done(1'b0, lat, nbusy);
      check_eq("busy_start_latency", 64'(lat), 64'd3);
      check_eq("busy_start_ignored", {56'd0, product4}, 64'd15);

      // start in the done cycle is accepted
      begin_op(1'b0, 1'b0, 8'd7, 8'd7);
      check_eq("b2b_busy", {63'd0, busy4}, 64'd1);
      check_eq("b2b_product_kept", {56'd0, product4}, 64'd15);
      wait_done(1'b0, lat, nbusy);
      check_eq("b2b_latency", 64'(lat), 64'd5);
      check_eq("b2b_product", {56'd0, product4}, 64'd49);

      // asynchronous reset mid-operation
      begin_op(1'b0, 1'b0, 8'd9, 8'd9);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_busy", {63'd0, busy4}, 64'd0);
      check_eq("rst_mid_done", {63'd0, done4}, 64'd0);
      check_eq("rst_mid_product", {56'd0, product4}, 64'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("rst_no_result", {63'd0, done4}, 64'd0);
      begin_op(1'b0, 1'b0, 8'd2, 8'd3);
      wait_done(1'b0, lat, nbusy);
      check_eq("post_rst_2x3", {56'd0, product4}, 64'd6);

      // WIDTH=8
      begin_op(1'b1, 1'b0, 8'hFF, 8'hFF);
      wait_done(1'b1, lat, nbusy);
      check_eq("w8_latency", 64'(lat), 64'd9);
      check_eq("w8_u255x255", {48'd0, product8}, 64'hFE01);
      begin_op(1'b1, 1'b1, 8'h80, 8'h7F);
      wait_done(1'b1, lat, nbusy);
      check_eq("w8_m128x127", {48'd0, product8}, 64'hC080);
      begin_op(1'b1, 1'b1, 8'h80, 8'h80);
      wait_done(1'b1, lat, nbusy);
      check_eq("w8_m128xm128", {48'd0, product8}, 64'h4000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
